// File: rtl/sync_fifo_ctrl_if.sv
// Push/pop handshake and ram control bundle between the FIFO controller and its users.
// The controller takes the slave view; producer/consumer logic takes the master view.
interface sync_fifo_ctrl_if #(
  parameter int unsigned ADDRESS_SIZE = 5
);

  logic                    push;
  logic                    pop;
  logic                    clr_err;
  logic                    w_en;
  logic                    r_en;
  logic [ADDRESS_SIZE-1:0] w_adrs;
  logic [ADDRESS_SIZE-1:0] r_adrs;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [ADDRESS_SIZE:0]   count;
  logic                    rd_valid;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output push,
    output pop,
    output clr_err,
    input  w_en,
    input  r_en,
    input  w_adrs,
    input  r_adrs,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  count,
    input  rd_valid,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  push,
    input  pop,
    input  clr_err,
    output w_en,
    output r_en,
    output w_adrs,
    output r_adrs,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output count,
    output rd_valid,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller sequencing a dual-port ram with a registered read port.
// Owns the pointers, occupancy, registered status flags and sticky error flags.
module sync_fifo_ctrl #(
  parameter int unsigned ADDRESS_SIZE = 5,
  parameter int unsigned MEM_DEPTH    = 32,
  parameter int unsigned AF_THRESH    = 28,
  parameter int unsigned AE_THRESH    = 4
) (
  input logic             clk,
  input logic             reset,
  sync_fifo_ctrl_if.slave bus
);

  localparam int unsigned PtrW = ADDRESS_SIZE + 1;

  localparam logic [PtrW-1:0] DepthVal = PtrW'(MEM_DEPTH);
  localparam logic [PtrW-1:0] AfVal    = PtrW'(AF_THRESH);
  localparam logic [PtrW-1:0] AeVal    = PtrW'(AE_THRESH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            almost_full_q, almost_full_d;
  logic            almost_empty_q, almost_empty_d;
  logic            rd_valid_q, rd_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic push_acc;
  logic pop_acc;

  // Acceptance is gated by this cycle's registered flags, never by next-state values.
  assign push_acc = bus.push & ~full_q;
  assign pop_acc  = bus.pop & ~empty_q;

  always_comb begin
    wr_ptr_d       = wr_ptr_q + PtrW'(push_acc);
    rd_ptr_d       = rd_ptr_q + PtrW'(pop_acc);
    count_d        = count_q + PtrW'(push_acc) - PtrW'(pop_acc);
    full_d         = (count_d == DepthVal);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AfVal);
    almost_empty_d = (count_d <= AeVal);
    rd_valid_d     = pop_acc;
    // Set condition takes priority over clr_err.
    overflow_d     = (bus.push & full_q) | (overflow_q & ~bus.clr_err);
    underflow_d    = (bus.pop & empty_q) | (underflow_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      rd_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      rd_valid_q     <= rd_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign bus.w_en         = push_acc;
  assign bus.r_en         = pop_acc;
  assign bus.w_adrs       = wr_ptr_q[ADDRESS_SIZE-1:0];
  assign bus.r_adrs       = rd_ptr_q[ADDRESS_SIZE-1:0];
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.count        = count_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Occupancy must always agree with the pointer distance.
  a_count_ptrs: assert property (@(posedge clk) disable iff (reset)
    count_q == (wr_ptr_q - rd_ptr_q));

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= DepthVal);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl with a behavioural registered-read ram attached.
module tb_sync_fifo_ctrl;

  localparam int AW    = 5;
  localparam int Depth = 32;
  localparam int AfTh  = 28;
  localparam int AeTh  = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.ADDRESS_SIZE(AW)) bus ();

  sync_fifo_ctrl #(
    .ADDRESS_SIZE(AW),
    .MEM_DEPTH   (Depth),
    .AF_THRESH   (AfTh),
    .AE_THRESH   (AeTh)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [Depth];
  logic [7:0] wdata;
  logic [7:0] r_data;

  always @(posedge clk) begin
    if (bus.w_en) mem[bus.w_adrs] <= wdata;
    if (bus.r_en) r_data <= mem[bus.r_adrs];
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] m_fifo [$];
  logic [7:0] exp_q  [$];
  int         m_count;
  logic [5:0] m_wptr;
  logic [5:0] m_rptr;
  bit         m_ovf;
  bit         m_unf;
  bit         m_rdv;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_count = 0;
    m_wptr  = '0;
    m_rptr  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_rdv   = 1'b0;
  endtask

  task automatic check_all();
    check_eq("count", 32'(bus.count), 32'(m_count));
    check_eq("full", 32'(bus.full), 32'(m_count == Depth));
    check_eq("empty", 32'(bus.empty), 32'(m_count == 0));
    check_eq("almost_full", 32'(bus.almost_full), 32'(m_count >= AfTh));
    check_eq("almost_empty", 32'(bus.almost_empty), 32'(m_count <= AeTh));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_eq("underflow", 32'(bus.underflow), 32'(m_unf));
    check_eq("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
    if (m_rdv && exp_q.size() > 0) check_eq("r_data", 32'(r_data), 32'(exp_q.pop_front()));
  endtask

  // Entered #1 after a posedge; drives one cycle of stimulus and checks both phases.
  task automatic do_cycle(input bit p, input bit q, input bit c, input logic [7:0] d);
    bit m_full;
    bit m_empty;
    bit pa;
    bit qa;
    bus.push    = p;
    bus.pop     = q;
    bus.clr_err = c;
    wdata       = d;
    #1;
    m_full  = (m_count == Depth);
    m_empty = (m_count == 0);
    pa      = p && !m_full;
    qa      = q && !m_empty;
    check_eq("w_en", 32'(bus.w_en), 32'(pa));
    check_eq("r_en", 32'(bus.r_en), 32'(qa));
    if (pa) check_eq("w_adrs", 32'(bus.w_adrs), 32'(m_wptr[AW-1:0]));
    if (qa) check_eq("r_adrs", 32'(bus.r_adrs), 32'(m_rptr[AW-1:0]));
    if (qa) begin
      exp_q.push_back(m_fifo.pop_front());
      m_rptr++;
    end
    if (pa) begin
      m_fifo.push_back(d);
      m_wptr++;
    end
    m_count = m_count + int'(pa) - int'(qa);
    m_ovf   = (p && m_full) || (m_ovf && !c);
    m_unf   = (q && m_empty) || (m_unf && !c);
    m_rdv   = qa;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    wdata       = '0;
    model_reset();
    #22;
    check_all();
    check_eq("reset_w_en", 32'(bus.w_en), 32'd0);
    check_eq("reset_r_en", 32'(bus.r_en), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_cycle(0, 0, 0, 8'h00);

    // Fill to full.
    for (int i = 0; i < Depth; i++) do_cycle(1, 0, 0, 8'(i));
    check_eq("filled_full", 32'(bus.full), 32'd1);

    // Overflow, set-wins against clr_err, then clear.
    do_cycle(1, 0, 0, 8'hAA);
    do_cycle(1, 0, 1, 8'hBB);
    check_eq("ovf_set_wins", 32'(bus.overflow), 32'd1);
    do_cycle(0, 0, 1, 8'h00);
    check_eq("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Drain; the extra idle cycle retires the last read.
    for (int i = 0; i < Depth; i++) do_cycle(0, 1, 0, 8'h00);
    do_cycle(0, 0, 0, 8'h00);
    check_eq("drained_empty", 32'(bus.empty), 32'd1);

    // Steady-state push+pop at count 1 across the address wrap.
    do_cycle(1, 0, 0, 8'h40);
    for (int i = 0; i < 40; i++) do_cycle(1, 1, 0, 8'(8'h50 + i));
    do_cycle(0, 1, 0, 8'h00);
    do_cycle(1, 1, 0, 8'hC3);
    check_eq("underflow_cnt1", 32'(bus.count), 32'd1);
    check_eq("underflow_set", 32'(bus.underflow), 32'd1);

    // Build up to 11, pop to 10, then reset in the middle of a pop cycle.
    for (int i = 0; i < 10; i++) do_cycle(1, 0, 0, 8'(8'h90 + i));
    do_cycle(0, 1, 0, 8'h00);
    check_eq("pre_reset_count", 32'(bus.count), 32'd10);
    bus.pop = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check_eq("async_r_en", 32'(bus.r_en), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    bus.pop = 1'b0;
    reset   = 1'b0;

    // Post-reset traffic restarts from address 0.
    do_cycle(0, 0, 0, 8'h00);
    do_cycle(1, 0, 0, 8'h11);
    do_cycle(1, 1, 0, 8'h22);
    do_cycle(0, 1, 0, 8'h00);
    do_cycle(0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the team's dual-port ram block as a synchronous FIFO for the pipelined CPU.
- Owns the write/read pointers, occupancy count and status flags.
- Drives the ram's write enable, read enable, write address and read address.
- Gives producers and consumers a push/pop handshake, with read data returned through the ram's registered read port.

Parameters:
ADDRESS_SIZE, 5, ram address width; pointers are ADDRESS_SIZE+1 bits (extra wrap bit).
MEM_DEPTH, 32, FIFO depth in entries; must equal 2**ADDRESS_SIZE.
AF_THRESH, 28, almost_full asserts when count >= AF_THRESH.
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH.

Ports:
clk  input  1  single system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
push  input  1  producer write request; data is presented to the ram directly by the producer.
pop  input  1  consumer read request.
clr_err  input  1  clears the overflow/underflow sticky flags.
w_en  output  1  ram write enable; combinational, = push_acc.
r_en  output  1  ram read enable; combinational, = pop_acc.
w_adrs  output  ADDRESS_SIZE  ram write address = wr_ptr[ADDRESS_SIZE-1:0].
r_adrs  output  ADDRESS_SIZE  ram read address = rd_ptr[ADDRESS_SIZE-1:0].
full  output  1  registered; count == MEM_DEPTH; also drives the ram full input.
empty  output  1  registered; count == 0; also drives the ram empty input.
almost_full  output  1  registered threshold flag.
almost_empty  output  1  registered threshold flag.
count  output  ADDRESS_SIZE+1  registered occupancy, range 0..MEM_DEPTH.
rd_valid  output  1  ram r_data holds the popped word; one cycle after pop_acc.
overflow  output  1  sticky; a push was attempted while full.
underflow  output  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset (async, asserted): all state goes to the values below, independent of clk, and holds while reset is high.
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - rd_valid = 0, overflow = 0, underflow = 0.
  - Contents are logically discarded; the ram itself is not cleared.
- Acceptance uses the registered flags of the current cycle:
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
- Push + pop when full: pop is accepted, push is rejected and overflow is set. Next cycle count = MEM_DEPTH-1.
- Push + pop when empty: push is accepted, pop is rejected and underflow is set. Next cycle count = 1.
- Push + pop, neither full nor empty: both accepted, count unchanged, both pointers advance.
- Pointers increment by 1 per accepted op, modulo 2**(ADDRESS_SIZE+1). The low bits wrap from MEM_DEPTH-1 to 0 with no bubble.
- Count next value: count + push_acc - pop_acc. Never exceeds MEM_DEPTH, never goes below 0.
- Flags are registered from the next count, so they are valid in the same cycle count updates:
  - full = (count_next == MEM_DEPTH).
  - empty = (count_next == 0).
  - almost_full = (count_next >= AF_THRESH).
  - almost_empty = (count_next <= AE_THRESH).
- Invariant: count == wr_ptr - rd_ptr (mod 2**(ADDRESS_SIZE+1)); the verification engineer checks it every cycle.
- Read latency: 1 cycle. r_en and r_adrs are asserted in cycle N; rd_valid = 1 and r_data is valid in cycle N+1. rd_valid is 0 in any cycle not following a pop_acc.
- Write: w_en and w_adrs are asserted in the push cycle, and the ram captures the data on that edge. A word written in cycle N is poppable from cycle N+1 (empty deasserts at N+1).
- Sticky error flags:
  - overflow sets on (push & full); underflow sets on (pop & empty).
  - clr_err clears both flags.
  - If a set condition and clr_err occur in the same cycle, the set wins.
  - A rejected op never changes the pointers or count.
- Reset asserted mid-stream: any in-flight rd_valid is dropped, and the next rd_valid after reset release is 0.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, full=0, rd_valid=0; w_en=r_en=0.
- 32 consecutive pushes of 0x00..0x1F -> count ramps to 32. almost_full rises when count reaches 28; full=1 after the 32nd push; w_adrs sequence is 0..31.
- Push while full, then clr_err -> overflow=1 with count still 32 and no write; after clr_err, overflow=0.
- Pop all 32 entries -> rd_valid one cycle after each r_en; r_data = 0x00..0x1F in order; empty=1 at end; almost_empty rises at count 4.
- From count=1, push+pop every cycle for 40 cycles -> count stays 1 and addresses wrap 31->0 cleanly. Then push+pop at count=0 -> push accepted, underflow=1, count=1.
- Assert reset asynchronously mid-pop with count=10 -> all outputs take their reset values immediately, with no wait for a clock edge.
